// File: rtl/scan_decoder_if.sv
// Bus bundle for scan_decoder: the control inputs and the registered decode outputs.
interface scan_decoder_if #(
  parameter int unsigned N = 3
);
  localparam int unsigned LINES = 1 << N;

  logic             en;
  logic             mode;
  logic             load;
  logic [N-1:0]     addr;
  logic [LINES-1:0] y;
  logic [N-1:0]     cur;
  logic             wrap;

  modport master (
    output en, mode, load, addr,
    input  y, cur, wrap
  );

  modport slave (
    input  en, mode, load, addr,
    output y, cur, wrap
  );
endinterface

// File: rtl/scan_decoder.sv
// Registered N-to-2^N one-hot decoder with enable and programmable-rate auto-scan.
module scan_decoder #(
  parameter int unsigned N          = 3,
  parameter int unsigned SCAN_DIV   = 4,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  scan_decoder_if.slave  bus
);
  localparam int unsigned LINES = 1 << N;
  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [LINES-1:0] Y_IDLE = ACTIVE_LOW ? {LINES{1'b1}} : {LINES{1'b0}};
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [N-1:0]     CUR_LAST = N'(LINES - 1);

  logic [N-1:0]     cur_q,  cur_d;
  logic [DIV_W-1:0] div_q,  div_d;
  logic             mode_q, mode_d;
  logic             wrap_q, wrap_d;
  logic [LINES-1:0] y_q,    y_d;

  // Next-state: hold when disabled, else direct decode or scan step by priority.
  always_comb begin
    cur_d  = cur_q;
    div_d  = div_q;
    mode_d = mode_q;
    wrap_d = 1'b0;
    y_d    = Y_IDLE;
    if (bus.en) begin
      mode_d = bus.mode;
      if (!bus.mode) begin
        cur_d = bus.addr;
        div_d = '0;
      end else if (bus.mode != mode_q) begin
        // First scan cycle restarts the divider; position kept unless loaded.
        div_d = '0;
        if (bus.load) cur_d = bus.addr;
      end else if (bus.load) begin
        cur_d = bus.addr;
        div_d = '0;
      end else if (div_q == DIV_LAST) begin
        div_d  = '0;
        cur_d  = cur_q + N'(1);
        wrap_d = (cur_q == CUR_LAST);
      end else begin
        div_d = div_q + DIV_W'(1);
      end
      y_d = LINES'(1) << cur_d;
      if (ACTIVE_LOW) y_d = ~y_d;
    end
  end

  // State and output registers; async clear to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q  <= '0;
      div_q  <= '0;
      mode_q <= 1'b0;
      wrap_q <= 1'b0;
      y_q    <= Y_IDLE;
    end else begin
      cur_q  <= cur_d;
      div_q  <= div_d;
      mode_q <= mode_d;
      wrap_q <= wrap_d;
      y_q    <= y_d;
    end
  end

  assign bus.y    = y_q;
  assign bus.cur  = cur_q;
  assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder: default build plus an active-low, divide-by-1 build.
module tb_scan_decoder;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  scan_decoder_if #(.N(3)) bus_a ();
  scan_decoder_if #(.N(3)) bus_b ();

  scan_decoder #(.N(3), .SCAN_DIV(4), .ACTIVE_LOW(1'b0)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  scan_decoder #(.N(3), .SCAN_DIV(1), .ACTIVE_LOW(1'b1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       mode;
    logic       load;
    logic [2:0] addr;
    logic [7:0] exp_y;
    logic [2:0] exp_cur;
    logic       exp_wrap;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_a(input string nm, input logic [7:0] ey, input logic [2:0] ec, input logic ew);
    chk({nm, ".y"},    32'(bus_a.y),    32'(ey));
    chk({nm, ".cur"},  32'(bus_a.cur),  32'(ec));
    chk({nm, ".wrap"}, 32'(bus_a.wrap), 32'(ew));
  endtask

  initial begin
    logic [7:0] ey;
    checks = 0;
    errors = 0;
    bus_a.en = 1'b0; bus_a.mode = 1'b0; bus_a.load = 1'b0; bus_a.addr = '0;
    bus_b.en = 1'b0; bus_b.mode = 1'b0; bus_b.load = 1'b0; bus_b.addr = '0;

    // Direct sweep 0..7, then a disabled cycle holding cur, then re-enable.
    for (int i = 0; i < 8; i++) begin
      vecs[i].en = 1'b1; vecs[i].mode = 1'b0; vecs[i].load = 1'b0;
      vecs[i].addr = 3'(i);
      vecs[i].exp_y = 8'(1) << i;
      vecs[i].exp_cur = 3'(i);
      vecs[i].exp_wrap = 1'b0;
    end
    vecs[8] = '{en: 1'b0, mode: 1'b0, load: 1'b0, addr: 3'd2, exp_y: 8'h00, exp_cur: 3'd7, exp_wrap: 1'b0};
    vecs[9] = '{en: 1'b1, mode: 1'b0, load: 1'b1, addr: 3'd2, exp_y: 8'h04, exp_cur: 3'd2, exp_wrap: 1'b0};

    do_reset();
    chk_a("reset_a", 8'h00, 3'd0, 1'b0);
    chk("reset_b.y", 32'(bus_b.y), 32'h0000_00FF);
    chk("reset_b.wrap", 32'(bus_b.wrap), 32'd0);

    for (int i = 0; i < 10; i++) begin
      bus_a.en = vecs[i].en; bus_a.mode = vecs[i].mode;
      bus_a.load = vecs[i].load; bus_a.addr = vecs[i].addr;
      step();
      chk($sformatf("vec%0d", i), 32'(bus_a.y), 32'(vecs[i].exp_y));
      chk($sformatf("vec%0d.cur", i), 32'(bus_a.cur), 32'(vecs[i].exp_cur));
      chk($sformatf("vec%0d.wrap", i), 32'(bus_a.wrap), 32'(vecs[i].exp_wrap));
    end

    // Free-running scan from reset: step every 4 cycles, wrap on edge 33.
    bus_a.en = 1'b0; bus_a.mode = 1'b0; bus_a.load = 1'b0;
    do_reset();
    bus_a.en = 1'b1; bus_a.mode = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      step();
      ey = 8'(1) << (((c - 1) / 4) % 8);
      chk_a($sformatf("scan_c%0d", c), ey, 3'(((c - 1) / 4) % 8), c == 33);
    end

    // Load at div=2: jump to 5, next advance 4 edges after the load.
    bus_a.en = 1'b0; bus_a.mode = 1'b0;
    do_reset();
    bus_a.en = 1'b1; bus_a.mode = 1'b1;
    repeat (3) step();
    bus_a.load = 1'b1; bus_a.addr = 3'd5;
    step();
    bus_a.load = 1'b0; bus_a.addr = 3'd0;
    chk_a("load_now", 8'h20, 3'd5, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk_a($sformatf("load_hold%0d", k), 8'h20, 3'd5, 1'b0);
    end
    step();
    chk_a("load_adv", 8'h40, 3'd6, 1'b0);

    // Enable gap at cur=3, div=1: outputs idle, position and divider held.
    bus_a.en = 1'b0; bus_a.mode = 1'b0;
    do_reset();
    bus_a.en = 1'b1; bus_a.mode = 1'b1;
    repeat (14) step();
    chk_a("gap_pre", 8'h08, 3'd3, 1'b0);
    bus_a.en = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk_a($sformatf("gap%0d", k), 8'h00, 3'd3, 1'b0);
    end
    bus_a.en = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      step();
      chk_a($sformatf("gap_resume%0d", k), 8'h08, 3'd3, 1'b0);
    end
    step();
    chk_a("gap_adv", 8'h10, 3'd4, 1'b0);

    // Active-low, divide-by-1 build: one step per cycle, wrap every 8.
    bus_a.en = 1'b0; bus_a.mode = 1'b0;
    do_reset();
    chk("al_reset.y", 32'(bus_b.y), 32'h0000_00FF);
    bus_b.en = 1'b1; bus_b.mode = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      step();
      ey = ~(8'(1) << ((c - 1) % 8));
      chk($sformatf("al_c%0d.y", c), 32'(bus_b.y), 32'(ey));
      chk($sformatf("al_c%0d.cur", c), 32'(bus_b.cur), 32'((c - 1) % 8));
      chk($sformatf("al_c%0d.wrap", c), 32'(bus_b.wrap), 32'(c == 9 || c == 17));
    end
    bus_b.en = 1'b0; bus_b.mode = 1'b0;

    // Async reset between edges at cur=6, then restart from 0.
    do_reset();
    bus_a.en = 1'b1; bus_a.mode = 1'b1;
    repeat (26) step();
    chk_a("arst_pre", 8'h40, 3'd6, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk_a("arst_now", 8'h00, 3'd0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk_a($sformatf("arst_run%0d", k), 8'h01, 3'd0, 1'b0);
    end
    step();
    chk_a("arst_adv", 8'h02, 3'd1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
